// File: rtl/hamming_enc_arbiter_pkg.sv
// Purpose: shared constants, types and parity helper for the Hamming(15,11) encoder arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hamming_enc_arbiter_pkg;

  localparam int DATA_W = 11;
  localparam int CODE_W = 15;

  // Parity bit positions inside the 15-bit codeword
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int P8_POS = 7;

  // Codeword position of data bit v[i] (d1..d11 fill the non-power-of-two slots)
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

  // Output register occupancy
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Returns {p8, p4, p2, p1} for an 11-bit data word
  function automatic logic [3:0] hamming_parity(input logic [DATA_W-1:0] v);
    logic p1, p2, p4, p8;
    p1 = v[0] ^ v[1] ^ v[3] ^ v[4] ^ v[6] ^ v[8] ^ v[10];
    p2 = v[0] ^ v[2] ^ v[3] ^ v[5] ^ v[6] ^ v[9] ^ v[10];
    p4 = v[1] ^ v[2] ^ v[3] ^ v[7] ^ v[8] ^ v[9] ^ v[10];
    p8 = v[4] ^ v[5] ^ v[6] ^ v[7] ^ v[8] ^ v[9] ^ v[10];
    return {p8, p4, p2, p1};
  endfunction

endpackage

// File: rtl/hamming_enc_arbiter_calcula_hamming.sv
// Purpose: combinational Hamming(15,11) encoder, data word in, codeword out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, output follows input.
module calcula_hamming
  import hamming_enc_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] entrada,
  output logic [CODE_W-1:0] saida
);

  logic [3:0] par;

  // Scatter data bits into their slots and drop the four parity bits in
  always_comb begin
    saida = '0;
    par   = hamming_parity(entrada);
    for (int i = 0; i < DATA_W; i++) begin
      saida[DATA_POS[i]] = entrada[i];
    end
    saida[P1_POS] = par[0];
    saida[P2_POS] = par[1];
    saida[P4_POS] = par[2];
    saida[P8_POS] = par[3];
  end

endmodule

// File: rtl/hamming_enc_arbiter.sv
// Purpose: round-robin shares one Hamming(15,11) encoder between N requesters into a registered output.
// Latency: 1 cycle from accepted word to cw_data; one word per cycle sustained.
// Backpressure: req_ready is low for everyone while the output register is full and cw_ready is low.
module hamming_enc_arbiter
  import hamming_enc_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*DATA_W-1:0]    req_data,
  output logic [N-1:0]           req_ready,
  output logic                   cw_valid,
  input  logic                   cw_ready,
  output logic [CODE_W-1:0]      cw_data,
  output logic [$clog2(N)-1:0]   cw_src,
  output logic [CW-1:0]          cw_count
);

  localparam int SW = $clog2(N);

  out_state_e        state_q;
  out_state_e        state_d;
  logic [SW-1:0]     rr_ptr;
  logic              grant_vld;
  logic [SW-1:0]     grant_idx;
  logic [SW-1:0]     rr_next;
  logic [DATA_W-1:0] grant_word;
  logic [CODE_W-1:0] grant_code;
  logic              load;
  logic              xfer;
  logic              consume;

  // Output register can take a word when empty or being drained this cycle
  assign load    = !cw_valid || cw_ready;
  assign consume = cw_valid && cw_ready;
  // Reset gating keeps req_ready low while rst_n is asserted
  assign xfer    = rst_n && load && grant_vld;

  // Round-robin scan: first pass from rr_ptr upwards, second pass wraps below rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req_valid[i] && (SW'(i) >= rr_ptr)) begin
        grant_vld = 1'b1;
        grant_idx = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req_valid[i] && (SW'(i) < rr_ptr)) begin
        grant_vld = 1'b1;
        grant_idx = SW'(i);
      end
    end
  end

  // Steer the granted word into the shared encoder and raise its ready
  always_comb begin
    grant_word = '0;
    req_ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_word   = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = xfer;
      end
    end
  end

  // Pointer advances past the winner, wrapping at N (N need not be a power of two)
  always_comb begin
    if (grant_idx == SW'(N - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = grant_idx + SW'(1);
    end
  end

  calcula_hamming u_enc (
    .entrada (grant_word),
    .saida   (grant_code)
  );

  // Output register occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill on transfer; drain only when consumed without a same-cycle reload
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (xfer) state_d = OUT_FULL;
      OUT_FULL:  if (consume && !xfer) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Valid is a direct decode of the occupancy state
  always_comb begin
    cw_valid = (state_q == OUT_FULL);
  end

  // Capture codeword, source tag and next arbitration start on every transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_data <= '0;
      cw_src  <= '0;
      rr_ptr  <= '0;
    end else if (xfer) begin
      cw_data <= grant_code;
      cw_src  <= grant_idx;
      rr_ptr  <= rr_next;
    end
  end

  // Count codewords handed to the sink; wraps naturally at 2^CW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_count <= '0;
    end else if (consume) begin
      cw_count <= cw_count + CW'(1);
    end
  end

endmodule

// File: doc/hamming_enc_arbiter.md
Name: hamming_enc_arbiter

Overview:
- Shares one combinational Hamming(15,11) encoder between N requesters.
- Each requester offers an 11-bit data word over a valid/ready handshake.
- A round-robin arbiter picks one requester per accepted transfer; its word is encoded and captured in a single registered output stage with its own valid/ready handshake and source tag.
- Sits between the data producers and the codeword sink (serialiser or memory write path).

Parameters:
- N, 4, number of requesters (2..8).
- SW, $clog2(N), width of the source tag (derived; not overridable).
- CW, 16, width of the accepted-codeword counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  N  requester i has a word on req_data.
- req_data  in  N*11  word i in bits [11*i+10 : 11*i].
- req_ready  out  N  one-hot or zero; word i accepted this cycle.
- cw_valid  out  1  cw_data and cw_src hold a codeword.
- cw_ready  in  1  sink accepts the codeword this cycle.
- cw_data  out  15  Hamming codeword.
  - Parity bits at positions 0, 1, 3, 7.
  - Data bits d1..d11 at positions 2, 4, 5, 6, 8..14.
- cw_src  out  SW  index of the requester that produced cw_data.
- cw_count  out  CW  number of codewords handed to the sink; wraps modulo 2^CW.

Behaviour:
- Reset (async, rst_n=0): cw_valid=0, cw_data=0, cw_src=0, cw_count=0, rr_ptr=0. req_ready=0 while in reset.
- Output register states:
  - EMPTY (cw_valid=0).
  - FULL (cw_valid=1).
- load = !cw_valid | cw_ready. The register can take a new word this cycle.
- Arbitration is combinational, each cycle:
  - Scan requesters starting at rr_ptr, wrapping, for i = rr_ptr, rr_ptr+1, ..., N-1, 0, ...
  - The first i with req_valid[i]=1 is the grant g.
  - If no req_valid is set, there is no grant.
- req_ready[g] = load & grant_exists. All other req_ready bits are 0.
- req_ready never depends on req_valid of a different requester's word being stable. It may depend combinationally on req_valid and cw_ready.
- Transfer on clock edge where req_valid[g] & req_ready[g]:
  - cw_data <= encode(req_data[g]).
  - cw_src <= g.
  - cw_valid <= 1.
  - rr_ptr <= (g+1) mod N.
- Sink consumes (cw_valid & cw_ready) with no new transfer: cw_valid <= 0. cw_data and cw_src keep their value.
- Simultaneous consume and transfer: register reloads in the same cycle. cw_valid stays 1, giving full throughput of one word per cycle.
- FULL and cw_ready=0: hold cw_data, cw_src, cw_valid; all req_ready=0; rr_ptr unchanged.
- cw_count increments by 1 on every cycle with cw_valid & cw_ready. It wraps from 2^CW-1 to 0.
- Latency: a word accepted at edge k is visible on cw_data after edge k. That is 1 cycle, with no combinational path from req_data to cw_data.
- Fairness: with all N requesters continuously valid and cw_ready=1, grants rotate 0,1,...,N-1,0,...
- Requester behaviour on withdrawal:
  - A requester may drop req_valid before being granted; no word is lost or duplicated.
  - Data is sampled only on the transfer edge.
- Reset asserted mid-transfer:
  - Outputs clear immediately (async).
  - A pending codeword is discarded and not counted.
- Encoding (identical to the team's encoder, v = 11-bit word):
  - p1 = v0^v1^v3^v4^v6^v8^v10
  - p2 = v0^v2^v3^v5^v6^v9^v10
  - p4 = v1^v2^v3^v7^v8^v9^v10
  - p8 = v4^v5^v6^v7^v8^v9^v10

Decomposition:
- Shared package holds:
  - DATA_W=11, CODE_W=15.
  - Parity position constants 0/1/3/7.
  - The data-position map as a localparam array.
- One sub-module: instantiate the existing combinational encoder calcula_hamming (entrada[10:0] -> saida[14:0]) on the muxed granted word.
- Arbiter and output register stay in hamming_enc_arbiter.

Test Plan:
1. Reset then single requester, N=4: req_valid=0001, req_data[0]=11'h001, cw_ready=1.
   - req_ready=0001 for one cycle.
   - Next cycle cw_valid=1, cw_data=15'h0007, cw_src=0.
   - Then cw_count=1.
2. Encoding corners, one word each from requester 2:
   - 11'h000 -> 15'h0000.
   - 11'h7FF -> 15'h7FFF.
   - 11'h010 -> 15'h0181.
   - cw_src=2 for each.
3. Round-robin, all four valid continuously, cw_ready=1:
   - cw_src sequence 0,1,2,3,0,1 on consecutive cycles.
   - Exactly one req_ready bit high per cycle.
4. Backpressure:
   - Fill register from requester 1, hold cw_ready=0 for 5 cycles with requesters 0 and 3 valid.
   - Expect req_ready=0000 throughout and cw_data/cw_src stable.
   - Raise cw_ready: the next grant is requester 3 (rr_ptr=2, scan 2 then 3).
5. Counter wrap:
   - Preload via 65535 consumes (or CW=4 build, 15 consumes), then one more consume.
   - Expect cw_count=0.
6. Async reset mid-stream:
   - Drop rst_n while cw_valid=1 and between edges.
   - Expect cw_valid=0 and cw_count=0 immediately.
   - After release, the first grant goes to the lowest-indexed valid requester.
